// File: rtl/counter8_scheduler.sv
// Shared-register sequencer: two requesters load q round-robin via req/ack; otherwise q counts when en=1 or holds.
// Latency: grant is decided from the sampled req/ack; q, ack, state and owner update on that same edge.
// Backpressure: a requester holds req until ack is seen; a request whose ack is high this cycle is masked.
module counter8_scheduler #(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       state,
    output logic             owner
);

    localparam logic [1:0] ST_HOLD  = 2'b00;
    localparam logic [1:0] ST_COUNT = 2'b01;
    localparam logic [1:0] ST_LOAD  = 2'b10;

    logic prio;
    logic m0;
    logic m1;
    logic grant_vld;
    logic grant_idx;

    // Masking by the live ack keeps a held request from being granted twice in a row.
    always_comb begin
        m0        = req0 & ~ack0;
        m1        = req1 & ~ack1;
        grant_vld = m0 | m1;
        grant_idx = (m0 & m1) ? prio : m1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= RESET_VAL;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            state <= ST_HOLD;
            owner <= 1'b0;
            prio  <= 1'b0;
        end else if (grant_vld) begin
            q     <= grant_idx ? d1 : d0;
            ack0  <= ~grant_idx;
            ack1  <= grant_idx;
            state <= ST_LOAD;
            owner <= grant_idx;
            prio  <= ~grant_idx;
        end else if (en) begin
            q     <= q + WIDTH'(1);
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            state <= ST_COUNT;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            state <= ST_HOLD;
        end
    end

endmodule

// File: tb/tb_counter8_scheduler.sv
// Scoreboarded bench: stimulus pushes expected responses from a reference model, a monitor pops and compares.
module tb_counter8_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       req0 = 1'b0;
    logic [2:0] d0 = '0;
    logic       req1 = 1'b0;
    logic [2:0] d1 = '0;
    logic       ack0;
    logic       ack1;
    logic [2:0] q;
    logic [1:0] state;
    logic       owner;

    counter8_scheduler #(.WIDTH(3), .RESET_VAL(3'd0)) dut (
        .clk(clk), .reset(reset), .en(en),
        .req0(req0), .d0(d0), .req1(req1), .d1(d1),
        .ack0(ack0), .ack1(ack1), .q(q), .state(state), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] q;
        logic       ack0;
        logic       ack1;
        logic [1:0] state;
        logic       owner;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference model state: plain integers, updated by the spec's per-edge rules.
    int m_q = 0;
    int m_ack[2] = '{0, 0};
    int m_owner = 0;
    int m_prio = 0;
    int m_state = 0;

    task automatic step(input bit r, input bit e, input bit a0, input int x0,
                        input bit a1, input int x1);
        int req[2];
        int dat[2];
        int elig[2];
        int winner;
        exp_t ex;
        @(negedge clk);
        reset = r; en = e; req0 = a0; d0 = 3'(x0); req1 = a1; d1 = 3'(x1);
        @(posedge clk);
        req = '{int'(a0), int'(a1)};
        dat = '{x0 % 8, x1 % 8};
        for (int i = 0; i < 2; i++) elig[i] = (req[i] == 1 && m_ack[i] == 0) ? 1 : 0;
        winner = -1;
        if (elig[0] == 1 && elig[1] == 1) winner = m_prio;
        else if (elig[0] == 1) winner = 0;
        else if (elig[1] == 1) winner = 1;
        if (r) begin
            m_q = 0; m_ack = '{0, 0}; m_state = 0; m_owner = 0; m_prio = 0;
        end else if (winner >= 0) begin
            m_q = dat[winner];
            m_ack = '{0, 0};
            m_ack[winner] = 1;
            m_state = 2;
            m_owner = winner;
            m_prio = 1 - winner;
        end else if (e) begin
            m_q = (m_q + 1) % 8;
            m_ack = '{0, 0};
            m_state = 1;
        end else begin
            m_ack = '{0, 0};
            m_state = 0;
        end
        ex.q = 3'(m_q);
        ex.ack0 = m_ack[0][0];
        ex.ack1 = m_ack[1][0];
        ex.state = 2'(m_state);
        ex.owner = m_owner[0];
        exp_q.push_back(ex);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q", int'(q), int'(e.q));
                chk("ack0", int'(ack0), int'(e.ack0));
                chk("ack1", int'(ack1), int'(e.ack1));
                chk("state", int'(state), int'(e.state));
                chk("owner", int'(owner), int'(e.owner));
                chk("ack_excl", int'(ack0 & ack1), 0);
            end
        end
    end

    initial begin
        int p0;
        int p1;
        int x0;
        int x1;
        // Reset held two cycles with a live request and en.
        step(1, 1, 1, 5, 0, 0);
        step(1, 1, 1, 5, 0, 0);
        // Load 6, then count 7,0,1 and hold.
        step(0, 0, 1, 6, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Single load of 5, then count.
        step(0, 1, 1, 5, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // Contention from reset.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 2, 1, 7);
        // Held single request from requester 1.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 3);
        // Reset in the cycle ack1 is high, then re-arbitration from prio 0.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 1, 7);
        step(0, 0, 1, 2, 1, 7);
        step(1, 0, 1, 2, 1, 7);
        step(0, 0, 1, 2, 1, 7);
        step(0, 0, 1, 2, 1, 7);
        // Randomized traffic: requesters mostly follow the hold-until-ack protocol.
        p0 = 0; p1 = 0; x0 = 0; x1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_ack[0] == 1 || p0 == 0) begin
                p0 = ($urandom_range(0, 2) != 0) ? 1 : 0;
                x0 = $urandom_range(0, 7);
            end
            if (m_ack[1] == 1 || p1 == 0) begin
                p1 = ($urandom_range(0, 2) != 0) ? 1 : 0;
                x1 = $urandom_range(0, 7);
            end
            if ($urandom_range(0, 15) == 0) x0 = $urandom_range(0, 7);
            step(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 1'(p0), x0, 1'(p1), x1);
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
